// File: rtl/mc_control_unit_hs.sv
// mc_control_unit_hs: multi-cycle RV32I control FSM with imem/dmem
// request/ready handshakes, optional M-extension wait state and trap.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   instrCode             instruction register contents
//   imem_ready/dmem_ready memory accept/complete
//   md_done               multiply/divide result valid
//   imem_req/dmem_req     memory requests, held until ready
//   irWe                  instruction register load strobe
//   md_start              one-cycle MD start pulse
//   regFileWe, aluSrcMuxSel, dataWe, branch, jal, jalr, PCEn
//   aluControl            ALU operation
//   RFWDSrcMuxSel         write-back source select
//   trap, trap_cause      halted flag and cause (01 illegal, 10 bus)
//   instret               retired-instruction counter
module mc_control_unit_hs #(
    parameter int M_EXT       = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instrCode,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    input  logic                 md_done,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 irWe,
    output logic                 md_start,
    output logic                 regFileWe,
    output logic                 aluSrcMuxSel,
    output logic                 dataWe,
    output logic                 branch,
    output logic                 jal,
    output logic                 jalr,
    output logic                 PCEn,
    output logic [3:0]           aluControl,
    output logic [2:0]           RFWDSrcMuxSel,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [INSTRET_W-1:0] instret
);

    localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_L  = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_LU = 7'b0110111;
    localparam logic [6:0] OP_AU = 7'b0010111;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_JL = 7'b1100111;

    typedef enum logic [3:0] {
        FETCH, DECODE, R_EXE, MD_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE,
        J_EXE, JL_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB, TRAP
    } state_t;

    state_t        state, next;
    logic [TW-1:0] tcnt;
    logic [1:0]    cause_q, cause_d;
    logic          md_busy;
    logic          waiting;
    logic          timeout;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] alu_def;
    logic       unused_bits;

    assign opcode      = instrCode[6:0];
    assign funct3      = instrCode[14:12];
    assign funct7      = instrCode[31:25];
    assign alu_def     = {instrCode[30], funct3};
    assign unused_bits = ^{instrCode[24:15], instrCode[11:7]};

    // A memory wait cycle: a handshake state whose ready is still low.
    always_comb begin
        waiting = 1'b0;
        if (state == FETCH)
            waiting = !imem_ready;
        else if (state == S_MEM || state == L_MEM)
            waiting = !dmem_ready;
    end

    assign timeout = (MEM_TIMEOUT != 0) && (tcnt == TMAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            tcnt    <= '0;
            cause_q <= 2'b00;
            md_busy <= 1'b0;
            instret <= '0;
        end else begin
            state <= next;
            if (next != state)
                tcnt <= '0;
            else if (waiting && MEM_TIMEOUT != 0)
                tcnt <= tcnt + 1'b1;
            if (next == TRAP && state != TRAP)
                cause_q <= cause_d;
            // Marks MD_EXE cycles after the first so md_start stays a pulse.
            md_busy <= (state == MD_EXE) && !md_done;
            if (PCEn)
                instret <= instret + 1'b1;
        end
    end

    always_comb begin
        next          = state;
        cause_d       = 2'b00;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        irWe          = 1'b0;
        md_start      = 1'b0;
        regFileWe     = 1'b0;
        aluSrcMuxSel  = 1'b0;
        dataWe        = 1'b0;
        branch        = 1'b0;
        jal           = 1'b0;
        jalr          = 1'b0;
        PCEn          = 1'b0;
        aluControl    = 4'b0000;
        RFWDSrcMuxSel = 3'b000;
        trap          = 1'b0;

        unique case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    irWe = 1'b1;
                    next = DECODE;
                end else if (timeout) begin
                    next    = TRAP;
                    cause_d = 2'b10;
                end
            end
            DECODE: begin
                cause_d = 2'b01;
                unique case (opcode)
                    OP_R: begin
                        if (funct7 == 7'b0000001)
                            next = (M_EXT != 0) ? MD_EXE : TRAP;
                        else
                            next = R_EXE;
                    end
                    OP_I:    next = I_EXE;
                    OP_L:    next = L_EXE;
                    OP_S:    next = S_EXE;
                    OP_B:    next = B_EXE;
                    OP_LU:   next = LU_EXE;
                    OP_AU:   next = AU_EXE;
                    OP_J:    next = J_EXE;
                    OP_JL:   next = JL_EXE;
                    default: next = TRAP;
                endcase
            end
            R_EXE: begin
                regFileWe  = 1'b1;
                aluControl = alu_def;
                PCEn       = 1'b1;
                next       = FETCH;
            end
            I_EXE: begin
                regFileWe    = 1'b1;
                aluSrcMuxSel = 1'b1;
                // Only SRAI needs bit 30; otherwise it is immediate data.
                aluControl   = (funct3 == 3'b101) ? alu_def : {1'b0, funct3};
                PCEn         = 1'b1;
                next         = FETCH;
            end
            B_EXE: begin
                branch     = 1'b1;
                aluControl = alu_def;
                PCEn       = 1'b1;
                next       = FETCH;
            end
            LU_EXE: begin
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = 3'b010;
                aluControl    = alu_def;
                PCEn          = 1'b1;
                next          = FETCH;
            end
            AU_EXE: begin
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = 3'b011;
                aluControl    = alu_def;
                PCEn          = 1'b1;
                next          = FETCH;
            end
            J_EXE: begin
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = 3'b100;
                jal           = 1'b1;
                aluControl    = alu_def;
                PCEn          = 1'b1;
                next          = FETCH;
            end
            JL_EXE: begin
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = 3'b100;
                jal           = 1'b1;
                jalr          = 1'b1;
                PCEn          = 1'b1;
                next          = FETCH;
            end
            MD_EXE: begin
                md_start      = !md_busy;
                aluControl    = alu_def;
                RFWDSrcMuxSel = 3'b101;
                if (md_done) begin
                    regFileWe = 1'b1;
                    PCEn      = 1'b1;
                    next      = FETCH;
                end
            end
            S_EXE: begin
                aluSrcMuxSel = 1'b1;
                next         = S_MEM;
            end
            S_MEM: begin
                aluSrcMuxSel = 1'b1;
                dmem_req     = 1'b1;
                dataWe       = 1'b1;
                aluControl   = alu_def;
                if (dmem_ready) begin
                    PCEn = 1'b1;
                    next = FETCH;
                end else if (timeout) begin
                    next    = TRAP;
                    cause_d = 2'b10;
                end
            end
            L_EXE: begin
                aluSrcMuxSel  = 1'b1;
                RFWDSrcMuxSel = 3'b001;
                next          = L_MEM;
            end
            L_MEM: begin
                aluSrcMuxSel  = 1'b1;
                RFWDSrcMuxSel = 3'b001;
                dmem_req      = 1'b1;
                aluControl    = alu_def;
                if (dmem_ready) begin
                    next = L_WB;
                end else if (timeout) begin
                    next    = TRAP;
                    cause_d = 2'b10;
                end
            end
            L_WB: begin
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = 3'b001;
                aluControl    = alu_def;
                PCEn          = 1'b1;
                next          = FETCH;
            end
            TRAP: begin
                trap = 1'b1;
            end
            default: next = FETCH;
        endcase
    end

    assign trap_cause = cause_q;

endmodule
